// File: rtl/malu_seq.sv
// Iterative RV32M/RV64M multiply/divide unit: shift-add multiplier and restoring
// divider on operand magnitudes, sign fix-up in a final cycle, valid/ready on both sides.
module malu_seq #(
  parameter int XLEN  = 32,
  parameter int CNT_W = $clog2(XLEN) + 1
) (
  input  logic            clk_i,
  input  logic            rst_n_i,
  input  logic            valid_i,
  output logic            ready_o,
  input  logic [2:0]      op_i,
  input  logic [XLEN-1:0] data0_i,
  input  logic [XLEN-1:0] data1_i,
  input  logic            flush_i,
  output logic            valid_o,
  input  logic            ready_i,
  output logic [XLEN-1:0] data_o
);

  typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

  localparam logic [XLEN-1:0] MIN_VAL = {1'b1, {(XLEN-1){1'b0}}};

  state_t              state_reg, state_next;
  logic [2:0]          op_reg;
  logic                neg_a_reg, neg_b_reg;
  logic [CNT_W-1:0]    cnt_reg;
  logic [2*XLEN:0]     acc_reg;
  logic [XLEN-1:0]     mcand_reg;
  logic [XLEN-1:0]     rem_reg, quot_reg;
  logic [XLEN-1:0]     data_reg;

  logic                accept;
  logic                is_div, sgn_a, sgn_b, neg_a, neg_b;
  logic [XLEN-1:0]     mag_a, mag_b;
  logic                div_zero, div_ovf;
  logic [XLEN-1:0]     special_res;
  logic [XLEN:0]       hi_sum;
  logic [2*XLEN:0]     acc_step;
  logic [XLEN:0]       shifted, diff;
  logic [XLEN-1:0]     rem_step, quot_step;
  logic [2*XLEN-1:0]   prod, prod_fix;
  logic [XLEN-1:0]     quot_fix, rem_fix, fix_res;

  assign ready_o = (state_reg == IDLE);
  assign valid_o = (state_reg == DONE);
  assign data_o  = data_reg;
  assign accept  = valid_i && ready_o && !flush_i;

  // Operand decode: rs1 is signed for MUL/MULH/MULHSU/DIV/REM, rs2 for all of those but MULHSU.
  assign is_div   = op_i[2];
  assign sgn_a    = !op_i[0] || (op_i == 3'b001);
  assign sgn_b    = sgn_a && (op_i != 3'b010);
  assign neg_a    = sgn_a && data0_i[XLEN-1];
  assign neg_b    = sgn_b && data1_i[XLEN-1];
  assign mag_a    = neg_a ? -data0_i : data0_i;
  assign mag_b    = neg_b ? -data1_i : data1_i;
  assign div_zero = is_div && (data1_i == '0);
  assign div_ovf  = is_div && !op_i[0] && (data0_i == MIN_VAL) && (data1_i == '1);

  always_comb begin
    special_res = '0;
    if (div_zero)
      special_res = op_i[1] ? data0_i : '1;
    else if (div_ovf)
      special_res = op_i[1] ? '0 : MIN_VAL;
  end

  // Multiply step: conditional add into the high half, then shift the whole accumulator right.
  assign hi_sum   = acc_reg[2*XLEN:XLEN] + (acc_reg[0] ? {1'b0, mcand_reg} : '0);
  assign acc_step = {1'b0, hi_sum, acc_reg[XLEN-1:1]};

  // Divide step: the trial difference is negative exactly when its top bit is set.
  assign shifted   = {rem_reg, quot_reg[XLEN-1]};
  assign diff      = shifted - {1'b0, mcand_reg};
  assign rem_step  = diff[XLEN] ? shifted[XLEN-1:0] : diff[XLEN-1:0];
  assign quot_step = {quot_reg[XLEN-2:0], !diff[XLEN]};

  assign prod     = acc_reg[2*XLEN-1:0];
  assign prod_fix = (neg_a_reg ^ neg_b_reg) ? -prod : prod;
  assign quot_fix = (neg_a_reg ^ neg_b_reg) ? -quot_reg : quot_reg;
  assign rem_fix  = neg_a_reg ? -rem_reg : rem_reg;

  always_comb begin
    case (op_reg)
      3'b000:                 fix_res = prod_fix[XLEN-1:0];
      3'b001, 3'b010, 3'b011: fix_res = prod_fix[2*XLEN-1:XLEN];
      3'b100, 3'b101:         fix_res = quot_fix;
      default:                fix_res = rem_fix;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i)
      state_reg <= IDLE;
    else
      state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    if (flush_i) begin
      state_next = IDLE;
    end else begin
      case (state_reg)
        IDLE: if (accept) state_next = (div_zero || div_ovf) ? DONE : CALC;
        CALC: if (cnt_reg == CNT_W'(1)) state_next = FIX;
        FIX:  state_next = DONE;
        DONE: if (ready_i) state_next = IDLE;
        default: state_next = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      op_reg    <= '0;
      neg_a_reg <= 1'b0;
      neg_b_reg <= 1'b0;
      cnt_reg   <= '0;
      acc_reg   <= '0;
      mcand_reg <= '0;
      rem_reg   <= '0;
      quot_reg  <= '0;
      data_reg  <= '0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (accept) begin
            op_reg    <= op_i;
            neg_a_reg <= neg_a;
            neg_b_reg <= neg_b;
            cnt_reg   <= CNT_W'(XLEN);
            mcand_reg <= is_div ? mag_b : mag_a;
            acc_reg   <= {{(XLEN+1){1'b0}}, mag_b};
            quot_reg  <= mag_a;
            rem_reg   <= '0;
            if (div_zero || div_ovf)
              data_reg <= special_res;
          end
        end
        CALC: begin
          cnt_reg <= cnt_reg - CNT_W'(1);
          if (op_reg[2]) begin
            rem_reg  <= rem_step;
            quot_reg <= quot_step;
          end else begin
            acc_reg <= acc_step;
          end
        end
        FIX: begin
          if (!flush_i)
            data_reg <= fix_res;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: doc/malu_seq.md
Name: malu_seq

Overview:
- Parametrised, multi-cycle RV32M/RV64M execution unit covering all eight M-extension ops (MUL/MULH/MULHSU/MULHU/DIV/DIVU/REM/REMU).
- Uses an iterative shift-add multiplier and a restoring divider on operand magnitudes, with sign fix-up at the end.
- Sits in the EX stage beside the ALU. Issue and result each use a valid/ready handshake so the pipeline stalls while the unit is busy.
- A flush input aborts an in-flight operation on a branch or trap.

Parameters:
- XLEN, 32, operand and result width. Legal values are 32 and 64.
- CNT_W, $clog2(XLEN)+1, iteration counter width. Derived; not overridden.

Ports:
- clk_i  in  1  clock.
- rst_n_i  in  1  reset.
- valid_i  in  1  request valid.
- ready_o  out  1  unit can accept a request.
- op_i  in  3  operation, RISC-V funct3 encoding: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
- data0_i  in  XLEN  rs1 operand.
- data1_i  in  XLEN  rs2 operand.
- flush_i  in  1  abort the current operation.
- valid_o  out  1  result valid.
- ready_i  in  1  consumer accepts the result.
- data_o  out  XLEN  result.

Behaviour:
- Clocking and reset: one clock; reset is asynchronous and active-low. Clock port is clk_i and reset port is rst_n_i.
- Reset values: state=IDLE, ready_o=1, valid_o=0, data_o=0, counter=0, all datapath registers 0. Reset asserted mid-operation discards the operation immediately.
- FSM states: IDLE, CALC, FIX, DONE.
- IDLE:
  - ready_o=1.
  - Accept occurs on the edge where valid_i && ready_o && !flush_i. On accept, latch op, operand signs and magnitudes; counter=XLEN.
  - Normal case goes to CALC.
  - Special divide cases go directly to DONE with the result latched. Latency is 1 edge.
    - Divide by zero (data1_i==0): DIV/DIVU give all ones; REM/REMU give data0_i.
    - Signed overflow (DIV/REM, data0_i==MIN, data1_i==-1): DIV gives MIN; REM gives 0.
- Signedness:
  - Operands are taken as signed for MULH, DIV and REM.
  - For MULHSU, only rs1 is signed.
  - For MULHU, DIVU and REMU, both are unsigned.
  - MUL low half is sign-independent. It is still computed via magnitudes with negation when signs differ.
  - Magnitude = two's complement of the operand if signed and MSB=1, otherwise the raw operand.
- CALC, multiply:
  - One bit per cycle. If multiplier LSB=1, add the multiplicand to the high half of a 2*XLEN accumulator.
  - Shift right 1, keeping the carry-out.
- CALC, divide:
  - One bit per cycle. Shift {rem,quot} left 1 and trial-subtract the divisor.
  - If the result is non-negative, keep it and set quot LSB=1.
- CALC exit: counter decrements each cycle; leave to FIX when counter reaches 1 (exactly XLEN CALC cycles).
- FIX (1 cycle): apply sign and select the result.
  - MUL: product[XLEN-1:0].
  - MULH/MULHSU/MULHU: product[2*XLEN-1:XLEN]. The 2*XLEN product is negated before slicing when the result sign=1.
  - Quotient is negated if the dividend and divisor signs differ (signed ops only).
  - Remainder is negated if the dividend is negative (signed ops only).
- DONE:
  - valid_o=1; data_o is held stable until ready_i=1.
  - On the handshake edge go to IDLE with valid_o=0.
  - No new request is accepted in the same cycle; ready_o=0 outside IDLE.
- Normal latency: accept edge to valid_o high = XLEN+2 edges (34 for XLEN=32).
- flush_i: in any state, the next edge forces IDLE and valid_o=0, and the result is discarded. flush_i has priority over accept and over the result handshake.
- data_o holds its last value after DONE; only valid_o qualifies it.
- Widths: all intermediate arithmetic is XLEN+1 (divider) or 2*XLEN+1 (multiplier accumulator) bits. The product of two MIN magnitudes must not overflow.

Test Plan:
- MUL data0=0xFFFFFFF9 (-7), data1=3 -> data_o=0xFFFFFFEB. valid_o rises exactly 34 edges after accept; ready_o=0 throughout.
- MULH 0x80000000*0x80000000 -> 0x40000000. MULHSU 0xFFFFFFFF*0xFFFFFFFF -> 0xFFFFFFFF. MULHU 0xFFFFFFFF*0xFFFFFFFF -> 0xFFFFFFFE.
- DIV 0xFFFFFFF9/2 -> 0xFFFFFFFD. REM 0xFFFFFFF9/2 -> 0xFFFFFFFF. DIVU 100/7 -> 14. REMU 100/7 -> 2.
- DIVU 5/0 -> 0xFFFFFFFF and REM 5/0 -> 5, each valid 1 edge after accept. DIV 0x80000000/0xFFFFFFFF -> 0x80000000; REM of the same operands -> 0. All with 1-edge latency.
- Backpressure: hold ready_i=0 for 10 cycles in DONE -> valid_o and data_o stable. ready_i=1 -> IDLE next edge, ready_o=1, then a back-to-back second op completes correctly.
- Flush at CALC cycle 5 -> IDLE next edge, valid_o never asserted, the following op is correct. Deassert rst_n_i mid-CALC -> outputs at reset values asynchronously. Repeat MUL/DIV checks with XLEN=64 (e.g. MULHU all-ones -> 0xFFFFFFFFFFFFFFFE).
